// File: rtl/instruction_decode.sv
// instruction_decode: RV64I ID stage with 32x64 register file, immediate/control decode,
// load-use hazard detection and ID/EX pipeline register.
module instruction_decode #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [31:0]     instruction,
   input  logic [XLEN-1:0] pc_current,
   input  logic            stall,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            hazard_stall,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_rs1_data,
   output logic [XLEN-1:0] id_rs2_data,
   output logic [XLEN-1:0] id_imm,
   output logic [4:0]      id_rd,
   output logic [4:0]      id_rs1,
   output logic [4:0]      id_rs2,
   output logic [2:0]      id_funct3,
   output logic            id_funct7b5,
   output logic [6:0]      id_opcode,
   output logic            id_reg_write,
   output logic            id_mem_read,
   output logic            id_mem_write,
   output logic            id_branch,
   output logic            id_jump,
   output logic            id_alu_src_imm,
   output logic            id_word_op,
   output logic            id_illegal
);
   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                          OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011,
                          OP_IMM32 = 7'b0011011, OP_OP32 = 7'b0111011;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc, a, b, imm;
      logic [4:0]      rd, rs1, rs2;
      logic [2:0]      f3;
      logic            f7b5;
      logic [6:0]      opc;
      logic            rw, mr, mw, br, jp, ai, wo, ill;
   } idex_t;

   logic [XLEN-1:0] regs [NREGS];
   logic [4:0]      rs1, rs2, rd;
   logic [6:0]      opc;
   logic [XLEN-1:0] rs1_data, rs2_data, imm;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic            rw, mr, mw, br, jp, ai, wo, ill, use_rs1, use_rs2;
   idex_t           q, d;

   assign opc = instruction[6:0];
   assign rd  = instruction[11:7];
   assign rs1 = instruction[19:15];
   assign rs2 = instruction[24:20];

   assign imm_i = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
   assign imm_s = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
   assign imm_b = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
   assign imm_u = {{(XLEN-32){instruction[31]}}, instruction[31:12], 12'b0};
   assign imm_j = {{(XLEN-21){instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};

   // Writeback in the same cycle wins over the stale entry.
   assign rs1_data = (rs1 == 5'd0) ? '0 : (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
   assign rs2_data = (rs2 == 5'd0) ? '0 : (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];

   always_comb begin
      {rw, mr, mw, br, jp, ai, wo, ill} = '0;
      imm = '0;
      case (opc)
         OP_LUI, OP_AUIPC: begin rw = 1'b1; ai = 1'b1; imm = imm_u; end
         OP_JAL:           begin rw = 1'b1; jp = 1'b1; imm = imm_j; end
         OP_JALR:          begin rw = 1'b1; jp = 1'b1; ai = 1'b1; imm = imm_i; end
         OP_BRANCH:        begin br = 1'b1; imm = imm_b; end
         OP_LOAD:          begin rw = 1'b1; mr = 1'b1; ai = 1'b1; imm = imm_i; end
         OP_STORE:         begin mw = 1'b1; ai = 1'b1; imm = imm_s; end
         OP_IMM, OP_IMM32: begin rw = 1'b1; ai = 1'b1; wo = (opc == OP_IMM32); imm = imm_i; end
         OP_OP, OP_OP32:   begin rw = 1'b1; wo = (opc == OP_OP32); end
         default:          ill = (instruction != 32'h0);
      endcase
   end

   assign use_rs1 = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
   assign use_rs2 = opc == OP_BRANCH || opc == OP_STORE || opc == OP_OP || opc == OP_OP32;

   assign hazard_stall = in_valid && q.valid && q.mr && q.rd != 5'd0 &&
                         ((use_rs1 && q.rd == rs1) || (use_rs2 && q.rd == rs2));

   assign d = {1'b1, pc_current, rs1_data, rs2_data, imm, rd, rs1, rs2, instruction[14:12],
               instruction[30], opc, rw, mr, mw, br, jp, ai, wo, ill};

   always_ff @(posedge clk) begin
      if (rst)
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      else if (wb_en && wb_rd != 5'd0)
         regs[wb_rd] <= wb_data;
   end

   // Flush beats stall; a hazard or missing input inserts a bubble.
   always_ff @(posedge clk) begin
      if (rst || flush || (!stall && (hazard_stall || !in_valid)))
         q <= '0;
      else if (!stall)
         q <= d;
   end

   assign id_valid       = q.valid;
   assign id_pc          = q.pc;
   assign id_rs1_data    = q.a;
   assign id_rs2_data    = q.b;
   assign id_imm         = q.imm;
   assign id_rd          = q.rd;
   assign id_rs1         = q.rs1;
   assign id_rs2         = q.rs2;
   assign id_funct3      = q.f3;
   assign id_funct7b5    = q.f7b5;
   assign id_opcode      = q.opc;
   assign id_reg_write   = q.rw;
   assign id_mem_read    = q.mr;
   assign id_mem_write   = q.mw;
   assign id_branch      = q.br;
   assign id_jump        = q.jp;
   assign id_alu_src_imm = q.ai;
   assign id_word_op     = q.wo;
   assign id_illegal     = q.ill;
endmodule
